// File: rtl/p2s_serializer_pkg.sv
// Shared widths, word-frame field offsets and FSM encoding for the output
// serializer and its block buffer.
package p2s_serializer_pkg;

  localparam int IO_WIDTH    = 32;
  localparam int BLOCK_WIDTH = 128;
  localparam int WORD_WIDTH  = IO_WIDTH + 2;
  localparam int LAST_BIT    = IO_WIDTH + 1;
  localparam int TAG_BIT     = IO_WIDTH;
  localparam int BEATS       = BLOCK_WIDTH / IO_WIDTH;
  localparam int BEAT_WIDTH  = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  // Buffer entry: {tag, block}
  typedef logic [BLOCK_WIDTH:0] entry_t;

endpackage

// File: rtl/p2s_serializer_if.sv
// Block-in / word-out bus of the serializer; master is the environment
// (core + downstream), slave is the serializer itself.
interface p2s_serializer_if;
  import p2s_serializer_pkg::*;

  // Both sides are valid/ready: a transfer happens on a clk edge where
  // valid && ready; valid and its payload stay stable until that edge.
  logic                   in_valid;
  logic                   in_ready;
  logic [BLOCK_WIDTH-1:0] in_block;
  logic                   in_tag;
  logic                   out_valid;
  logic                   out_ready;
  logic [WORD_WIDTH-1:0]  out_word;

  modport master (
    output in_valid, in_block, in_tag, out_ready,
    input  in_ready, out_valid, out_word
  );

  modport slave (
    input  in_valid, in_block, in_tag, out_ready,
    output in_ready, out_valid, out_word
  );

endinterface

// File: rtl/p2s_block_buf.sv
// Circular store of {tag, block} entries with read/write pointers and an
// occupancy count that includes the block currently being serialized.
module p2s_block_buf
  import p2s_serializer_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     wr_en,
  input  entry_t                   wr_data,
  input  logic                     rd_en,
  output entry_t                   rd_data,
  output entry_t                   rd_next_data,
  output logic [$clog2(DEPTH):0]   cnt,
  output logic                     full
);

  localparam int PTR_WIDTH = $clog2(DEPTH);
  localparam logic [PTR_WIDTH:0] FULL_CNT = (PTR_WIDTH+1)'(DEPTH);

  entry_t               mem [DEPTH];
  logic [PTR_WIDTH-1:0] wr_ptr;
  logic [PTR_WIDTH-1:0] rd_ptr;
  logic [PTR_WIDTH-1:0] rd_ptr_nxt;

  assign rd_ptr_nxt = rd_ptr + 1'b1;

  // Storage is deliberately not cleared by reset or flush.
  always_ff @(posedge clk) begin
    if (wr_en && !flush) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr_nxt;
      case ({wr_en, rd_en})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  assign rd_data      = mem[rd_ptr];
  assign rd_next_data = mem[rd_ptr_nxt];
  assign full         = (cnt == FULL_CNT);

endmodule

// File: rtl/p2s_serializer.sv
// Buffers parallel SM4 blocks and emits each as BEATS {last, tag, data}
// words, most-significant word first, with no bubble between blocks.
module p2s_serializer
  import p2s_serializer_pkg::*;
#(
  parameter int BUF_DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  p2s_serializer_if.slave              bus,
  output logic                         buf_empty,
  output logic                         buf_full,
  output state_t                       dbg_state,
  output logic [$clog2(BUF_DEPTH):0]   dbg_cnt
);

  localparam int BUF_WIDTH = $clog2(BUF_DEPTH);
  localparam logic [BEAT_WIDTH-1:0] LAST_BEAT = BEAT_WIDTH'(BEATS - 1);
  localparam logic [BUF_WIDTH:0]    CNT_ONE   = (BUF_WIDTH+1)'(1);

  state_t                 state;
  state_t                 state_nxt;
  logic [BLOCK_WIDTH-1:0] shreg;
  logic                   tag;
  logic [BEAT_WIDTH-1:0]  beat;
  logic [BUF_WIDTH:0]     cnt;
  logic                   accept;
  logic                   advance;
  logic                   retire;
  logic                   load;
  entry_t                 load_data;
  entry_t                 rd_data;
  entry_t                 rd_next_data;

  assign accept  = bus.in_valid && bus.in_ready;
  assign advance = (state == SEND) && bus.out_ready;
  assign retire  = advance && (beat == LAST_BEAT);

  p2s_block_buf #(.DEPTH(BUF_DEPTH)) u_buf (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .wr_en        (accept),
    .wr_data      ({bus.in_tag, bus.in_block}),
    .rd_en        (retire),
    .rd_data      (rd_data),
    .rd_next_data (rd_next_data),
    .cnt          (cnt),
    .full         (buf_full)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      shreg <= '0;
      tag   <= 1'b0;
      beat  <= '0;
    end else if (flush) begin
      state <= IDLE;
      shreg <= '0;
      tag   <= 1'b0;
      beat  <= '0;
    end else begin
      state <= state_nxt;
      if (load) begin
        shreg <= load_data[BLOCK_WIDTH-1:0];
        tag   <= load_data[BLOCK_WIDTH];
        beat  <= '0;
      end else if (advance) begin
        shreg <= shreg << IO_WIDTH;
        beat  <= beat + 1'b1;
      end
    end
  end

  // On the final beat the next block is the stored successor, or, when the
  // buffer would drain, the block being accepted in that same cycle.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    load_data = rd_data;
    case (state)
      IDLE: begin
        if (cnt != '0) begin
          load      = 1'b1;
          state_nxt = SEND;
        end
      end
      SEND: begin
        if (retire) begin
          if (cnt != CNT_ONE) begin
            load      = 1'b1;
            load_data = rd_next_data;
          end else if (accept) begin
            load      = 1'b1;
            load_data = {bus.in_tag, bus.in_block};
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.out_valid = (state == SEND);
    bus.out_word  = '0;
    if (state == SEND) begin
      bus.out_word[LAST_BIT]       = (beat == LAST_BEAT);
      bus.out_word[TAG_BIT]        = tag;
      bus.out_word[IO_WIDTH-1:0]   = shreg[BLOCK_WIDTH-1 -: IO_WIDTH];
    end
    bus.in_ready = !buf_full;
    buf_empty    = (cnt == '0) && (state == IDLE);
    dbg_state    = state;
    dbg_cnt      = cnt;
  end

endmodule
